// File: rtl/rank_filter_stream.sv
// Streaming rank filter: loads one WINDOW_SIZE x WINDOW_SIZE window, sorts each colour
// channel with an odd-even transposition network, and returns the median, min, max or centre pixel.
module rank_filter_stream #(
  parameter int CHANNELS    = 3,
  parameter int CH_WIDTH    = 8,
  parameter int WINDOW_SIZE = 3,
  parameter int DATA_WIDTH  = CHANNELS * CH_WIDTH
) (
  input  logic                  Filt_CLK,
  input  logic                  Filt_RSTn,
  input  logic                  Filt_START,
  input  logic [1:0]            Filt_MODE,
  input  logic                  Filt_CLR,
  input  logic                  Filt_IN_VLD,
  input  logic [DATA_WIDTH-1:0] Filt_IN_DATA,
  output logic                  Filt_IN_RDY,
  output logic                  Filt_OUT_VLD,
  input  logic                  Filt_OUT_RDY,
  output logic [DATA_WIDTH-1:0] Filt_RES,
  output logic                  Filt_BSY,
  output logic                  Filt_DNE
);

  localparam int N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int IDX_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_win [N];
  logic [DATA_WIDTH-1:0] w_pass [N];
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] r_centre;
  logic [DATA_WIDTH-1:0] r_res;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_pass;
  logic [1:0]            r_mode;
  logic                  r_outVld;
  logic                  r_dne;
  logic                  w_inFire;
  logic                  w_lastIn;
  logic                  w_sortDone;
  logic                  w_outFire;

  assign w_inFire   = (r_state == S_LOAD) && Filt_IN_VLD;
  assign w_lastIn   = w_inFire && (r_idx == IDX_W'(N - 1));
  assign w_sortDone = (r_state == S_SORT) && (r_pass == IDX_W'(N - 1));
  assign w_outFire  = (r_state == S_OUT) && r_outVld && Filt_OUT_RDY;

  assign Filt_IN_RDY  = (r_state == S_LOAD);
  assign Filt_BSY     = (r_state != S_IDLE);
  assign Filt_OUT_VLD = r_outVld;
  assign Filt_RES     = r_res;
  assign Filt_DNE     = r_dne;

  always_ff @(posedge Filt_CLK or negedge Filt_RSTn) begin
    if (!Filt_RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (Filt_START) w_nextState = S_LOAD;
      S_LOAD: if (w_lastIn) w_nextState = (r_mode == 2'b11) ? S_OUT : S_SORT;
      S_SORT: if (w_sortDone) w_nextState = S_OUT;
      S_OUT:  if (w_outFire) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (Filt_CLR) w_nextState = S_IDLE;
  end

  // One transposition pass: pairs start on even indices for even passes, odd for odd passes.
  // Every channel is compared and swapped on its own.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pass[i] = r_win[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(r_pass[0])) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (r_win[i][c*CH_WIDTH +: CH_WIDTH] > r_win[i+1][c*CH_WIDTH +: CH_WIDTH]) begin
            w_pass[i][c*CH_WIDTH +: CH_WIDTH]   = r_win[i+1][c*CH_WIDTH +: CH_WIDTH];
            w_pass[i+1][c*CH_WIDTH +: CH_WIDTH] = r_win[i][c*CH_WIDTH +: CH_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    w_sel = w_pass[N/2];
    case (r_mode)
      2'b01:   w_sel = w_pass[0];
      2'b10:   w_sel = w_pass[N-1];
      default: w_sel = w_pass[N/2];
    endcase
  end

  always_ff @(posedge Filt_CLK or negedge Filt_RSTn) begin
    if (!Filt_RSTn) begin
      for (int i = 0; i < N; i++) begin
        r_win[i] <= '0;
      end
      r_centre <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_pass   <= '0;
      r_mode   <= 2'b00;
      r_outVld <= 1'b0;
      r_dne    <= 1'b0;
    end else begin
      r_dne <= 1'b0;
      if (Filt_CLR) begin
        r_idx    <= '0;
        r_pass   <= '0;
        r_outVld <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Filt_START) begin
              r_mode <= Filt_MODE;
              r_idx  <= '0;
              r_pass <= '0;
            end
          end
          S_LOAD: begin
            if (w_inFire) begin
              r_win[r_idx] <= Filt_IN_DATA;
              r_idx        <= r_idx + 1'b1;
              if (w_lastIn) begin
                r_centre <= r_win[N/2];
                r_pass   <= '0;
              end
            end
          end
          S_SORT: begin
            for (int i = 0; i < N; i++) begin
              r_win[i] <= w_pass[i];
            end
            r_pass <= r_pass + 1'b1;
            if (w_sortDone) begin
              r_res    <= w_sel;
              r_outVld <= 1'b1;
            end
          end
          S_OUT: begin
            // Passthrough arrives here without a result yet; publish the centre one cycle later.
            if (!r_outVld) begin
              r_res    <= r_centre;
              r_outVld <= 1'b1;
            end else if (Filt_OUT_RDY) begin
              r_outVld <= 1'b0;
              r_dne    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rank_filter_stream.md
# rank_filter_stream

Parametrised, multi-channel successor to the single-window median filter in the pixel-processing path. It accepts one window of pixels over a valid/ready stream. It sorts each colour channel independently with a fixed-latency odd-even transposition network, then emits the median, minimum, maximum or unfiltered centre pixel over a valid/ready output. It sits between the window-fetch memory interface and the result write-back, driven by the control unit through a start/done handshake.

## Interface
- CHANNELS, 3, number of independent colour channels per pixel
- CH_WIDTH, 8, bits per channel (unsigned)
- WINDOW_SIZE, 3, window side; odd, ≥3; N = WINDOW_SIZE*WINDOW_SIZE pixels per window
- DATA_WIDTH, CHANNELS*CH_WIDTH, derived pixel width; channel c occupies bits [c*CH_WIDTH +: CH_WIDTH]

Ports:
- Filt_CLK  in  1  clock; all logic on rising edge
- Filt_RSTn  in  1  asynchronous, active-low reset
- Filt_START  in  1  one-cycle request to begin a window; honoured only in IDLE
- Filt_MODE  in  2  00 median, 01 min, 10 max, 11 passthrough centre; sampled when START is accepted
- Filt_CLR  in  1  synchronous abort; returns to IDLE from any state, no DNE
- Filt_IN_VLD  in  1  input pixel valid
- Filt_IN_DATA  in  DATA_WIDTH  input pixel, raster order within the window
- Filt_IN_RDY  out  1  high only in LOAD
- Filt_OUT_VLD  out  1  result valid; held until accepted
- Filt_OUT_RDY  in  1  downstream accepts result
- Filt_RES  out  DATA_WIDTH  filtered pixel; stable while OUT_VLD high
- Filt_BSY  out  1  high in any state other than IDLE
- Filt_DNE  out  1  one-cycle pulse on the cycle after the output handshake

## Operation
- States: IDLE, LOAD, SORT, OUT.
- IDLE: if START is high, latch MODE, clear the index, and go to LOAD.
- LOAD: on IN_VLD&&IN_RDY, write window[idx] and increment idx. IN_VLD gaps stall without loss.
- LOAD exit: on acceptance of pixel N-1, capture the centre pixel (index N/2) into a separate register.
  - Mode 11: go straight to OUT.
  - Otherwise: go to SORT with the pass counter cleared.
- SORT: one pass per cycle for exactly N passes.
  - Even pass p compares pairs (0,1),(2,3),…; odd pass compares (1,2),(3,4),….
  - Each compare swaps so the lower value sits at the lower index, per channel independently (unsigned compare).
  - Channels never move together; each channel is sorted on its own.
- SORT exit: the edge completing pass N-1 registers RES per channel and sets OUT_VLD.
  - Median: sorted[N/2].
  - Min: sorted[0].
  - Max: sorted[N-1].
- OUT: hold RES/OUT_VLD. On OUT_VLD&&OUT_RDY, clear OUT_VLD, return to IDLE, and assert DNE for one cycle.
- START outside IDLE is ignored. CLR has priority over every other event, including START and handshakes.
- CLR or reset mid-window discards partial data. The next window starts clean; stale window contents never leak.

## Timing
- Reset values: IN_RDY=0, OUT_VLD=0, RES=0, BSY=0, DNE=0, state IDLE, window/index/pass cleared.
- START accepted at edge t0: IN_RDY is high from t0+1.
- Last pixel accepted at edge t:
  - Modes 00/01/10: OUT_VLD rises at edge t+N (N SORT cycles).
  - Mode 11: OUT_VLD rises at edge t+1.
- Handshake completes at edge h: DNE is high during h..h+1 only; BSY falls at h. START at h+1 is honoured.
- Zero-backpressure, gap-free throughput (modes 00/01/10): 1 + N + N + 1 cycles per window (START, LOAD, SORT, OUT).
- Sorting is deterministic: no data-dependent latency.

## Test plan
- Reset/idle: hold RSTn low, then release -> all outputs 0, IN_RDY 0. Drive IN_VLD=1 without START -> nothing accepted, BSY stays 0.
- Median, CHANNELS=3, CH_WIDTH=8, WINDOW_SIZE=3. Pixel k (k=0..8) has ch0 = {9,1,8,2,7,3,6,4,5}[k], ch1 = 0xFF, ch2 = k.
  - Expect RES = 0x04FF05 and OUT_VLD exactly 9 cycles after the last accept.
  - Expect one DNE pulse after OUT_RDY.
- Same window, modes 01/10/11 -> RES = 0x00FF01, 0x08FF09, and 0x04FF07 (passthrough after 1 cycle).
- Backpressure and stalls:
  - Random IN_VLD gaps during LOAD -> same 0x04FF05.
  - OUT_RDY low for 20 cycles -> RES/OUT_VLD stable, no DNE until accepted.
  - START pulses during busy -> ignored.
- CLR after 4 pixels -> IDLE, no DNE. Then a full window of all 0x123456 -> RES 0x123456 (no stale data).
- Asynchronous RSTn asserted mid-SORT -> immediate reset values. WINDOW_SIZE=5 regression: 25 pixels of values 24..0 per channel -> median 12, latency 25 cycles.
